// File: rtl/flash_wr_packer.sv
// Byte-to-word packer feeding the flash write controller: packs host bytes low-first
// into 16-bit words, buffers them in a FIFO and hands them out with auto-incrementing addresses.
module flash_wr_packer #(
  parameter int         BUF_DEPTH = 32,
  parameter int         LVL_W     = 6,
  parameter logic [7:0] PAD_BYTE  = 8'hFF
) (
  input  logic             clkin_50,
  input  logic             sys_resetn,
  input  logic             start,
  input  logic [24:0]      start_addr,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             flush,
  output logic [15:0]      wr_data,
  output logic [24:0]      wr_addr,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic [15:0]      word_count,
  output logic [LVL_W-1:0] buf_level,
  output logic             busy,
  output logic             done,
  output logic             addr_wrap,
  output logic             drop_err
);
  localparam int AW = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [15:0]      mem [BUF_DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [LVL_W-1:0] level;
  logic             half;
  logic [7:0]       low;
  logic             full, empty, go;
  logic             accept, push_byte, push_pad, push, pop;
  logic [15:0]      push_data;

  assign full  = (level == LVL_W'(BUF_DEPTH));
  assign empty = (level == '0);
  assign go    = (state == S_IDLE) && start;

  // Only the registered full flag gates the high byte, so wr_ready never reaches byte_ready.
  assign byte_ready = (state == S_RUN) && !(half && full);
  assign accept     = byte_valid && byte_ready;
  assign push_byte  = accept && half;
  assign push_pad   = (state == S_FLUSH) && half && !full;
  assign push       = push_byte || push_pad;
  assign push_data  = push_pad ? {PAD_BYTE, low} : {byte_in, low};

  assign wr_valid  = !empty;
  assign pop       = wr_valid && wr_ready;
  assign wr_data   = wr_valid ? mem[rptr] : '0;
  assign buf_level = level;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (flush) state_nxt = S_FLUSH;
      S_FLUSH: if (empty && !half) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clkin_50 or negedge sys_resetn) begin
    if (!sys_resetn) state <= S_IDLE;
    else             state <= state_nxt;
  end

  // Storage carries no reset; wr_data is masked while the FIFO is empty.
  always_ff @(posedge clkin_50) begin
    if (push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clkin_50 or negedge sys_resetn) begin
    if (!sys_resetn) begin
      wptr       <= '0;
      rptr       <= '0;
      level      <= '0;
      half       <= 1'b0;
      low        <= '0;
      wr_addr    <= '0;
      word_count <= '0;
      addr_wrap  <= 1'b0;
    end else if (go) begin
      wptr       <= '0;
      rptr       <= '0;
      level      <= '0;
      half       <= 1'b0;
      wr_addr    <= start_addr;
      word_count <= '0;
      addr_wrap  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (pop && !push) level <= level - LVL_W'(1);
      if (push) begin
        half <= 1'b0;
      end else if (accept) begin
        half <= 1'b1;
        low  <= byte_in;
      end
      if (pop) begin
        wr_addr <= wr_addr + 25'd1;
        if (wr_addr == 25'h1FFFFFF) addr_wrap <= 1'b1;
        if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clkin_50 or negedge sys_resetn) begin
    if (!sys_resetn)                       drop_err <= 1'b0;
    else if (byte_valid && state != S_RUN) drop_err <= 1'b1;
    else if (go)                           drop_err <= 1'b0;
  end
endmodule
